audio_src_arb: RTL and testbench

Two-source arbiter for the stereo audio output path. It shares the single FIFO-style sample interface feeding the I2S/SPDIF/sigma-delta output block between a main stream (src0, e.g. the Linux audio DMA) and a priority alert stream (src1, e.g. OSD beeps). It grants ownership per stream rather than per frame, and inserts a short run of silent frames on every owner change to avoid clicks. It sits directly upstream of the output block and drives that block's fifo_* inputs.

---
 rtl/audio_arb_pkg.sv | 40 ++++
 rtl/audio_arb_idle_timer.sv | 42 ++++
 rtl/audio_src_arb.sv | 262 ++++++++++++++++++++++++++
 tb/tb_audio_src_arb.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_arb_pkg.sv
// -----------------------------------------------------------------------------
// audio_arb_pkg
// Shared types and constants for the two-source audio output arbiter.
//   state_e      : arbiter FSM state. The encoding equals the owner code, so
//                  the registered state can be reported directly as owner.
//   OWNER_*      : owner output encodings.
//   TIMER_W      : idle timer width.
//   GAP_CNT_W    : silent-gap frame counter width.
//   owner_of()   : maps an FSM state onto its owner code.
// -----------------------------------------------------------------------------
package audio_arb_pkg;

  localparam int TIMER_W   = 16;
  localparam int GAP_CNT_W = 8;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_SRC0 = 2'd1;
  localparam logic [1:0] OWNER_SRC1 = 2'd2;
  localparam logic [1:0] OWNER_GAP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SRC0 = 2'd1,
    S_SRC1 = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  function automatic logic [1:0] owner_of(input state_e s);
    logic [1:0] o;
    case (s)
      S_IDLE:  o = OWNER_NONE;
      S_SRC0:  o = OWNER_SRC0;
      S_SRC1:  o = OWNER_SRC1;
      S_GAP:   o = OWNER_GAP;
      default: o = OWNER_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/audio_arb_idle_timer.sv
// -----------------------------------------------------------------------------
// audio_arb_idle_timer
// Clearable 16-bit up-counter measuring how long the current owner has held
// its ready flag low. expired is high in the cycle whose increment would make
// the count reach IDLE_TIMEOUT, so the owner is released on that edge.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   clear    in   force the count back to zero on the next edge
//   expired  out  count has reached IDLE_TIMEOUT-1 (terminal count)
// -----------------------------------------------------------------------------
module audio_arb_idle_timer
  import audio_arb_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam logic [TIMER_W-1:0] TC_VALUE = TIMER_W'(IDLE_TIMEOUT - 1);

  logic [TIMER_W-1:0] count_r;

  // Idle counter: cleared on request, otherwise counts up and holds at max.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 16'd0;
    end else if (clear) begin
      count_r <= 16'd0;
    end else if (count_r != 16'hFFFF) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == TC_VALUE);

endmodule

// File: rtl/audio_src_arb.sv
// -----------------------------------------------------------------------------
// audio_src_arb
// Two-source arbiter in front of the audio output block. Ownership is granted
// per stream: src1 (alerts) preempts src0 (main stream), an owner that keeps
// its ready flag low for IDLE_TIMEOUT cycles is released, and every owner
// change inserts GAP_FRAMES silent frames to avoid clicks.
//
// Parameters:
//   IDLE_TIMEOUT  1..65535  idle cycles before an owner loses the path
//   GAP_FRAMES    0..255    zero frames per owner change (0 = no gap)
// Optional build macro:
//   AUDIO_ARB_STATS_EN  adds src0_frames, src1_frames, switch_count outputs
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   src0_left/right_data, src0_ready   main-stream frame and valid
//   src0_ack                           main-stream frame consumed
//   src1_left/right_data, src1_ready   alert-stream frame and valid
//   src1_ack                           alert-stream frame consumed
//   fifo_left/right_data, fifo_ready   frame presented to the output block
//   fifo_ack                           output block consumed the frame
//   owner                              0 none, 1 src0, 2 src1, 3 gap
//   src0_frames, src1_frames           saturating acked-frame counts (stats)
//   switch_count                       wrapping count of gap entries (stats)
// -----------------------------------------------------------------------------
module audio_src_arb
  import audio_arb_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1024,
  parameter int GAP_FRAMES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] src0_left_data,
  input  logic [31:0] src0_right_data,
  input  logic        src0_ready,
  output logic        src0_ack,
  input  logic [31:0] src1_left_data,
  input  logic [31:0] src1_right_data,
  input  logic        src1_ready,
  output logic        src1_ack,
  output logic [31:0] fifo_left_data,
  output logic [31:0] fifo_right_data,
  output logic        fifo_ready,
  input  logic        fifo_ack,
  output logic [1:0]  owner
`ifdef AUDIO_ARB_STATS_EN
  ,
  output logic [15:0] src0_frames,
  output logic [15:0] src1_frames,
  output logic [7:0]  switch_count
`endif
);

  localparam logic                 GAP_EN   = (GAP_FRAMES != 0);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_FRAMES);

  state_e               state_r;
  state_e               state_next_s;
  logic                 next_src1_r;       // gap target: 1 = src1, 0 = src0
  logic                 next_src1_next_s;
  logic [GAP_CNT_W-1:0] gap_cnt_r;
  logic [GAP_CNT_W-1:0] gap_cnt_next_s;
  logic                 owner_ready_s;
  logic                 in_src_s;
  logic                 timer_clear_s;
  logic                 timer_expired_s;
  logic                 timeout_s;

  // Ready flag of whichever source currently owns the path.
  always_comb begin
    owner_ready_s = 1'b0;
    in_src_s      = 1'b0;
    case (state_r)
      S_SRC0: begin
        owner_ready_s = src0_ready;
        in_src_s      = 1'b1;
      end
      S_SRC1: begin
        owner_ready_s = src1_ready;
        in_src_s      = 1'b1;
      end
      default: begin
        owner_ready_s = 1'b0;
        in_src_s      = 1'b0;
      end
    endcase
  end

  // Timer runs only while an owner is idle in its own state; any state change
  // (including a direct src0->src1 hand-over) starts the new owner from zero.
  assign timer_clear_s = (state_next_s != state_r) || owner_ready_s || !in_src_s;
  assign timeout_s     = timer_expired_s && in_src_s && !owner_ready_s;

  audio_arb_idle_timer #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear_s),
    .expired (timer_expired_s)
  );

  // Next-state, gap target and gap counter logic.
  always_comb begin
    state_next_s     = state_r;
    next_src1_next_s = next_src1_r;
    gap_cnt_next_s   = gap_cnt_r;
    case (state_r)
      S_IDLE: begin
        // Leaving idle never inserts a gap; src1 wins a tie.
        if (src1_ready) begin
          state_next_s = S_SRC1;
        end else if (src0_ready) begin
          state_next_s = S_SRC0;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_SRC0: begin
        if (src1_ready) begin
          if (GAP_EN) begin
            state_next_s     = S_GAP;
            next_src1_next_s = 1'b1;
            gap_cnt_next_s   = GAP_LOAD;
          end else begin
            state_next_s = S_SRC1;
          end
        end else if (timeout_s) begin
          // src1 is known idle here, so a timeout simply releases the path.
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_SRC0;
        end
      end
      S_SRC1: begin
        if (timeout_s) begin
          if (src0_ready) begin
            if (GAP_EN) begin
              state_next_s     = S_GAP;
              next_src1_next_s = 1'b0;
              gap_cnt_next_s   = GAP_LOAD;
            end else begin
              state_next_s = S_SRC0;
            end
          end else begin
            state_next_s = S_IDLE;
          end
        end else begin
          state_next_s = S_SRC1;
        end
      end
      S_GAP: begin
        // An alert arriving during a gap towards src0 takes over the target.
        if (src1_ready) begin
          next_src1_next_s = 1'b1;
        end else begin
          next_src1_next_s = next_src1_r;
        end
        if (fifo_ack) begin
          gap_cnt_next_s = gap_cnt_r - 8'd1;
          if (gap_cnt_r <= 8'd1) begin
            if (next_src1_r || src1_ready) begin
              state_next_s = S_SRC1;
            end else begin
              state_next_s = S_SRC0;
            end
          end else begin
            state_next_s = S_GAP;
          end
        end else begin
          gap_cnt_next_s = gap_cnt_r;
          state_next_s   = S_GAP;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // FSM state, gap target and gap counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      next_src1_r <= 1'b0;
      gap_cnt_r   <= 8'd0;
    end else begin
      state_r     <= state_next_s;
      next_src1_r <= next_src1_next_s;
      gap_cnt_r   <= gap_cnt_next_s;
    end
  end

  // Output mux: combinational from the registered state so data and ack pass
  // straight through with zero latency; an ack in a transition cycle belongs
  // to the outgoing owner because the mux follows state_r, not state_next_s.
  always_comb begin
    fifo_left_data  = 32'd0;
    fifo_right_data = 32'd0;
    fifo_ready      = 1'b0;
    src0_ack        = 1'b0;
    src1_ack        = 1'b0;
    case (state_r)
      S_SRC0: begin
        fifo_left_data  = src0_left_data;
        fifo_right_data = src0_right_data;
        fifo_ready      = src0_ready;
        src0_ack        = fifo_ack;
      end
      S_SRC1: begin
        fifo_left_data  = src1_left_data;
        fifo_right_data = src1_right_data;
        fifo_ready      = src1_ready;
        src1_ack        = fifo_ack;
      end
      S_GAP: begin
        fifo_ready = 1'b1;
      end
      default: begin
        fifo_ready = 1'b0;
      end
    endcase
  end

  assign owner = owner_of(state_r);

`ifdef AUDIO_ARB_STATS_EN
  logic [15:0] src0_frames_r;
  logic [15:0] src1_frames_r;
  logic [7:0]  switch_count_r;

  // Per-source acked-frame counters (saturating) and gap-entry counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      src0_frames_r  <= 16'd0;
      src1_frames_r  <= 16'd0;
      switch_count_r <= 8'd0;
    end else begin
      if (src0_ack && (src0_frames_r != 16'hFFFF)) begin
        src0_frames_r <= src0_frames_r + 16'd1;
      end else begin
        src0_frames_r <= src0_frames_r;
      end
      if (src1_ack && (src1_frames_r != 16'hFFFF)) begin
        src1_frames_r <= src1_frames_r + 16'd1;
      end else begin
        src1_frames_r <= src1_frames_r;
      end
      if ((state_next_s == S_GAP) && (state_r != S_GAP)) begin
        switch_count_r <= switch_count_r + 8'd1;
      end else begin
        switch_count_r <= switch_count_r;
      end
    end
  end

  assign src0_frames  = src0_frames_r;
  assign src1_frames  = src1_frames_r;
  assign switch_count = switch_count_r;
`endif

endmodule

// File: tb/tb_audio_src_arb.sv
// -----------------------------------------------------------------------------
// tb_audio_src_arb
// Self-checking bench for audio_src_arb. Two instances share the stimulus:
// dut with default parameters and dut_g0 with GAP_FRAMES=0, IDLE_TIMEOUT=16.
// Consumed frames are checked against a queue of expected frames that the
// stimulus pushes as it drives each frame.
// -----------------------------------------------------------------------------
module tb_audio_src_arb;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src0_left_data, src0_right_data;
  logic        src0_ready;
  logic [31:0] src1_left_data, src1_right_data;
  logic        src1_ready;
  logic        fifo_ack;

  logic        src0_ack, src1_ack, fifo_ready;
  logic [31:0] fifo_left_data, fifo_right_data;
  logic [1:0]  owner;

  logic        g0_src0_ack, g0_src1_ack, g0_fifo_ready;
  logic [31:0] g0_fifo_left_data, g0_fifo_right_data;
  logic [1:0]  g0_owner;

`ifdef AUDIO_ARB_STATS_EN
  logic [15:0] src0_frames, src1_frames, g0_src0_frames, g0_src1_frames;
  logic [7:0]  switch_count, g0_switch_count;
`endif

  int     pass_cnt  = 0;
  int     check_cnt = 0;
  frame_t exp_q[$];
  frame_t f;

  always #5 clk = ~clk;

  audio_src_arb dut (
    .clk             (clk),
    .reset           (reset),
    .src0_left_data  (src0_left_data),
    .src0_right_data (src0_right_data),
    .src0_ready      (src0_ready),
    .src0_ack        (src0_ack),
    .src1_left_data  (src1_left_data),
    .src1_right_data (src1_right_data),
    .src1_ready      (src1_ready),
    .src1_ack        (src1_ack),
    .fifo_left_data  (fifo_left_data),
    .fifo_right_data (fifo_right_data),
    .fifo_ready      (fifo_ready),
    .fifo_ack        (fifo_ack),
    .owner           (owner)
`ifdef AUDIO_ARB_STATS_EN
    ,
    .src0_frames     (src0_frames),
    .src1_frames     (src1_frames),
    .switch_count    (switch_count)
`endif
  );

  audio_src_arb #(
    .IDLE_TIMEOUT (16),
    .GAP_FRAMES   (0)
  ) dut_g0 (
    .clk             (clk),
    .reset           (reset),
    .src0_left_data  (src0_left_data),
    .src0_right_data (src0_right_data),
    .src0_ready      (src0_ready),
    .src0_ack        (g0_src0_ack),
    .src1_left_data  (src1_left_data),
    .src1_right_data (src1_right_data),
    .src1_ready      (src1_ready),
    .src1_ack        (g0_src1_ack),
    .fifo_left_data  (g0_fifo_left_data),
    .fifo_right_data (g0_fifo_right_data),
    .fifo_ready      (g0_fifo_ready),
    .fifo_ack        (fifo_ack),
    .owner           (g0_owner)
`ifdef AUDIO_ARB_STATS_EN
    ,
    .src0_frames     (g0_src0_frames),
    .src1_frames     (g0_src1_frames),
    .switch_count    (g0_switch_count)
`endif
  );

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    src0_ready = 1'b1; src1_ready = 1'b0; fifo_ack = 1'b1;
    src0_left_data = 32'hDEAD0000; src0_right_data = 32'hBEEF0000;
    src1_left_data = 32'h0; src1_right_data = 32'h0;
    tick(); tick();
    @(negedge clk);
    check_cnt++;
    if ({fifo_ready, src0_ack, src1_ack, owner} !== 5'b0 || fifo_left_data !== 32'h0 || fifo_right_data !== 32'h0)
      $display("FAIL reset_outputs: got ready=%b ack0=%b ack1=%b owner=%0d l=%h r=%h, expected all 0",
               fifo_ready, src0_ack, src1_ack, owner, fifo_left_data, fifo_right_data);
    else pass_cnt++;
    tick();
    reset = 1'b0; fifo_ack = 1'b0; src0_left_data = 32'h12340000; src0_right_data = 32'h56780000;
    @(negedge clk);
    check_cnt++;
    if (owner !== 2'd0) $display("FAIL idle_owner: got %0d expected 0", owner);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (owner !== 2'd1) $display("FAIL src0_grant_owner: got %0d expected 1", owner);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (fifo_left_data !== 32'h12340000 || fifo_ready !== 1'b1)
      $display("FAIL src0_passthrough: got l=%h ready=%b expected 12340000 ready=1", fifo_left_data, fifo_ready);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_preempt;
    for (int i = 0; i < 3; i++) begin
      src0_left_data = {16'h1000 + 16'(i), 16'h0000};
      src0_right_data = {16'h2000 + 16'(i), 16'h0000};
      fifo_ack = 1'b1;
      exp_q.push_back('{l: src0_left_data, r: src0_right_data});
      @(negedge clk);
      if (fifo_ready && fifo_ack) begin
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL pre_src0_frame: got unexpected frame l=%h, expected none", fifo_left_data);
        else begin
          f = exp_q.pop_front();
          if ({fifo_left_data, fifo_right_data} !== {f.l, f.r})
            $display("FAIL pre_src0_frame: got %h/%h expected %h/%h", fifo_left_data, fifo_right_data, f.l, f.r);
          else pass_cnt++;
        end
      end
      check_cnt++;
      if (src0_ack !== 1'b1 || src1_ack !== 1'b0)
        $display("FAIL pre_src0_ack: got ack0=%b ack1=%b expected 1/0", src0_ack, src1_ack);
      else pass_cnt++;
      tick();
    end
    fifo_ack = 1'b0; src1_ready = 1'b1;
    src1_left_data = 32'hBEEF0000; src1_right_data = 32'hF00D0000;
    @(negedge clk);
    check_cnt++;
    if (owner !== 2'd1) $display("FAIL pre_edge_owner: got %0d expected 1", owner);
    else pass_cnt++;
    tick();
    for (int i = 0; i < 4; i++) begin
      fifo_ack = 1'b1;
      exp_q.push_back('{l: 32'h0, r: 32'h0});
      @(negedge clk);
      if (fifo_ready && fifo_ack) begin
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL gap_frame: got unexpected frame l=%h, expected none", fifo_left_data);
        else begin
          f = exp_q.pop_front();
          if ({fifo_left_data, fifo_right_data} !== {f.l, f.r})
            $display("FAIL gap_frame: got %h/%h expected %h/%h", fifo_left_data, fifo_right_data, f.l, f.r);
          else pass_cnt++;
        end
      end
      check_cnt++;
      if (owner !== 2'd3 || fifo_ready !== 1'b1 || src0_ack !== 1'b0 || src1_ack !== 1'b0)
        $display("FAIL gap_state: got owner=%0d ready=%b ack0=%b ack1=%b expected 3/1/0/0",
                 owner, fifo_ready, src0_ack, src1_ack);
      else pass_cnt++;
      tick();
    end
    fifo_ack = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (owner !== 2'd2 || fifo_left_data !== 32'hBEEF0000)
      $display("FAIL after_gap_src1: got owner=%0d l=%h expected 2 beef0000", owner, fifo_left_data);
    else pass_cnt++;
    tick();
    for (int i = 0; i < 3; i++) begin
      src1_left_data = {16'hA000 + 16'(i), 16'h0000};
      src1_right_data = {16'hB000 + 16'(i), 16'h0000};
      fifo_ack = (i != 1);
      if (fifo_ack) exp_q.push_back('{l: src1_left_data, r: src1_right_data});
      @(negedge clk);
      if (fifo_ready && fifo_ack) begin
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL src1_frame: got unexpected frame l=%h, expected none", fifo_left_data);
        else begin
          f = exp_q.pop_front();
          if ({fifo_left_data, fifo_right_data} !== {f.l, f.r})
            $display("FAIL src1_frame: got %h/%h expected %h/%h", fifo_left_data, fifo_right_data, f.l, f.r);
          else pass_cnt++;
        end
      end
      check_cnt++;
      if (src1_ack !== fifo_ack || src0_ack !== 1'b0)
        $display("FAIL src1_ack_follow: got ack1=%b ack0=%b expected %b/0", src1_ack, src0_ack, fifo_ack);
      else pass_cnt++;
      tick();
    end
    fifo_ack = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    src1_ready = 1'b0; fifo_ack = 1'b0;
    src0_left_data = 32'hCAFE0000; src0_right_data = 32'h0BEE0000;
    n = 0;
    while (owner !== 2'd3 && n < 2000) begin
      tick();
      n++;
    end
    check_cnt++;
    if (n !== 1024) $display("FAIL timeout_cycles: got %0d expected 1024", n);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      fifo_ack = 1'b1;
      exp_q.push_back('{l: 32'h0, r: 32'h0});
      @(negedge clk);
      if (fifo_ready && fifo_ack) begin
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL to_gap_frame: got unexpected frame l=%h, expected none", fifo_left_data);
        else begin
          f = exp_q.pop_front();
          if ({fifo_left_data, fifo_right_data} !== {f.l, f.r})
            $display("FAIL to_gap_frame: got %h/%h expected %h/%h", fifo_left_data, fifo_right_data, f.l, f.r);
          else pass_cnt++;
        end
      end
      tick();
    end
    fifo_ack = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (owner !== 2'd1 || fifo_left_data !== 32'hCAFE0000)
      $display("FAIL timeout_to_src0: got owner=%0d l=%h expected 1 cafe0000", owner, fifo_left_data);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_simul_ack_preempt;
    int n;
    fifo_ack = 1'b1; src1_ready = 1'b1;
    src0_left_data = 32'h55550000; src0_right_data = 32'h66660000;
    exp_q.push_back('{l: src0_left_data, r: src0_right_data});
    @(negedge clk);
    check_cnt++;
    if (src0_ack !== 1'b1 || owner !== 2'd1)
      $display("FAIL simul_ack: got ack0=%b owner=%0d expected 1/1", src0_ack, owner);
    else pass_cnt++;
    if (fifo_ready && fifo_ack) begin
      check_cnt++;
      if (exp_q.size() == 0) $display("FAIL simul_frame: got unexpected frame l=%h, expected none", fifo_left_data);
      else begin
        f = exp_q.pop_front();
        if ({fifo_left_data, fifo_right_data} !== {f.l, f.r})
          $display("FAIL simul_frame: got %h/%h expected %h/%h", fifo_left_data, fifo_right_data, f.l, f.r);
        else pass_cnt++;
      end
    end
    tick();
    fifo_ack = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (owner !== 2'd3 || src0_ack !== 1'b0 || fifo_left_data !== 32'h0 || exp_q.size() != 0)
      $display("FAIL simul_next_gap: got owner=%0d ack0=%b l=%h pending=%0d expected 3/0/0/0",
               owner, src0_ack, fifo_left_data, exp_q.size());
    else pass_cnt++;
    n = 0;
    fifo_ack = 1'b1;
    while (owner !== 2'd2 && n < 20) begin
      tick();
      n++;
    end
    fifo_ack = 1'b0;
    check_cnt++;
    if (n !== 4) $display("FAIL simul_gap_len: got %0d expected 4", n);
    else pass_cnt++;
  endtask

  task automatic test_reset_midgap;
    int n;
    reset = 1'b1; src0_ready = 1'b0; src1_ready = 1'b0; fifo_ack = 1'b0;
    tick();
    reset = 1'b0; src0_ready = 1'b1;
    tick();
    src1_ready = 1'b1;
    tick();
    check_cnt++;
    if (owner !== 2'd3) $display("FAIL midgap_setup: got owner=%0d expected 3", owner);
    else pass_cnt++;
    fifo_ack = 1'b1;
    tick(); tick();
    fifo_ack = 1'b0; reset = 1'b1;
    tick();
    @(negedge clk);
    check_cnt++;
    if ({fifo_ready, src0_ack, src1_ack, owner} !== 5'b0 || fifo_left_data !== 32'h0)
      $display("FAIL midgap_reset: got ready=%b ack0=%b ack1=%b owner=%0d l=%h expected all 0",
               fifo_ready, src0_ack, src1_ack, owner, fifo_left_data);
    else pass_cnt++;
`ifdef AUDIO_ARB_STATS_EN
    check_cnt++;
    if (src0_frames !== 16'h0 || src1_frames !== 16'h0 || switch_count !== 8'h0)
      $display("FAIL midgap_stats: got %h/%h/%h expected 0/0/0", src0_frames, src1_frames, switch_count);
    else pass_cnt++;
`endif
    tick();
    reset = 1'b0; src0_ready = 1'b0; src1_ready = 1'b0;
    tick();
    check_cnt++;
    if (owner !== 2'd0) $display("FAIL midgap_stay_idle: got %0d expected 0", owner);
    else pass_cnt++;
    src0_ready = 1'b1;
    tick();
    src1_ready = 1'b1;
    tick();
    fifo_ack = 1'b1;
    n = 0;
    while (owner !== 2'd2 && n < 20) begin
      tick();
      n++;
    end
    fifo_ack = 1'b0;
    check_cnt++;
    if (n !== 4) $display("FAIL fresh_gap_len: got %0d expected 4", n);
    else pass_cnt++;
  endtask

  task automatic test_gap0;
    int n;
    reset = 1'b1; src0_ready = 1'b0; src1_ready = 1'b0; fifo_ack = 1'b0;
    tick();
    reset = 1'b0; src0_ready = 1'b1; src0_left_data = 32'h11110000;
    tick();
    check_cnt++;
    if (g0_owner !== 2'd1) $display("FAIL g0_src0: got owner=%0d expected 1", g0_owner);
    else pass_cnt++;
    src1_ready = 1'b1; src1_left_data = 32'h22220000;
    tick();
    @(negedge clk);
    check_cnt++;
    if (g0_owner !== 2'd2 || g0_fifo_left_data !== 32'h22220000 || g0_fifo_ready !== 1'b1)
      $display("FAIL g0_direct_preempt: got owner=%0d l=%h ready=%b expected 2 22220000 1",
               g0_owner, g0_fifo_left_data, g0_fifo_ready);
    else pass_cnt++;
    tick();
    src1_ready = 1'b0;
    n = 0;
    while (g0_owner !== 2'd1 && n < 100) begin
      tick();
      n++;
    end
    check_cnt++;
    if (n !== 16) $display("FAIL g0_timeout_direct: got %0d cycles expected 16", n);
    else pass_cnt++;
  endtask

`ifdef AUDIO_ARB_STATS_EN
  task automatic test_stats;
    reset = 1'b1; src0_ready = 1'b0; src1_ready = 1'b0; fifo_ack = 1'b0;
    tick();
    reset = 1'b0; src0_ready = 1'b1;
    tick();
    fifo_ack = 1'b1;
    repeat (70000) tick();
    fifo_ack = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (src0_frames !== 16'hFFFF || src1_frames !== 16'h0 || switch_count !== 8'h0)
      $display("FAIL stats_saturate: got %h/%h/%h expected ffff/0000/00", src0_frames, src1_frames, switch_count);
    else pass_cnt++;
    tick();
    src1_ready = 1'b1;
    tick();
    @(negedge clk);
    check_cnt++;
    if (switch_count !== 8'h1) $display("FAIL stats_switch: got %0d expected 1", switch_count);
    else pass_cnt++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_preempt();
    test_timeout();
    test_simul_ack_preempt();
    test_reset_midgap();
    test_gap0();
`ifdef AUDIO_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
